// File: rtl/l2_sched_pkg.sv
// Shared definitions for L2 request schedulers: width helpers, stream id type, FSM states.
package l2_sched_pkg;

    // Stream id width. A single stream still gets a 1-bit id so the port stays legal.
    function automatic int unsigned sw_width(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Fill-level width. It must hold 0..cap inclusive.
    function automatic int unsigned lw_width(input int unsigned cap);
        return $clog2(cap + 1);
    endfunction

    // Outstanding-count width. It must hold 0..max_out inclusive.
    function automatic int unsigned ow_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

    localparam int unsigned DefWays = 16;

    typedef logic [$clog2(DefWays)-1:0] sid_t;

    // Scheduler FSM states. Kept as plain constants so older schedulers can share them.
    typedef logic [0:0] sched_state_t;
    localparam sched_state_t StIdle  = 1'b0;
    localparam sched_state_t StOffer = 1'b1;

endpackage

// File: rtl/l2_sched_pick.sv
// Combinational picker: smallest key among eligible streams; ties go to the first stream
// at or after rr_ptr. The streams are rotated so rr_ptr sits at position 0, then a binary
// comparator tree reduces them. On equal keys the lower rotated position wins.
module l2_sched_pick import l2_sched_pkg::*; #(
    parameter int unsigned WAYS = 16,
    parameter int unsigned KW   = 6,
    parameter int unsigned SW   = sw_width(WAYS)
) (
    input  logic [WAYS-1:0]    elig,
    input  logic [WAYS*KW-1:0] keys,
    input  logic [SW-1:0]      rr_ptr,
    output logic               any,
    output logic [SW-1:0]      winner
);

    // Heap-indexed comparator tree. Leaves are at WAYS..2*WAYS-1 and the root is node 1.
    always_comb begin : p_tree
        logic          nv [2*WAYS];
        logic [KW-1:0] nk [2*WAYS];
        logic [SW-1:0] np [2*WAYS];
        logic [SW-1:0] idx;
        logic          take_r;
        for (int n = 0; n < 2 * WAYS; n++) begin
            nv[n] = 1'b0;
            nk[n] = '0;
            np[n] = '0;
        end
        idx    = '0;
        take_r = 1'b0;
        for (int j = 0; j < WAYS; j++) begin
            idx            = rr_ptr + SW'(j);
            nv[WAYS + j]   = elig[idx];
            nk[WAYS + j]   = keys[idx*KW +: KW];
            np[WAYS + j]   = SW'(j);
        end
        for (int n = WAYS - 1; n >= 1; n--) begin
            take_r = nv[2*n+1] && (!nv[2*n] || (nk[2*n+1] < nk[2*n]));
            nv[n]  = nv[2*n] || nv[2*n+1];
            nk[n]  = take_r ? nk[2*n+1] : nk[2*n];
            np[n]  = take_r ? np[2*n+1] : np[2*n];
        end
        any    = nv[1];
        winner = rr_ptr + np[1];
    end

endmodule

// File: rtl/l2_req_sched.sv
// Fill-aware L2 line request scheduler. It tracks outstanding requests per stream and offers
// the eligible stream with the fewest committed lines over a registered valid/ready handshake.
module l2_req_sched import l2_sched_pkg::*; #(
    parameter int unsigned WAYS    = 16,
    parameter int unsigned MAX_OUT = 8,
    parameter int unsigned CAP     = 16,
    parameter int unsigned SW      = sw_width(WAYS),
    parameter int unsigned LW      = lw_width(CAP),
    parameter int unsigned OW      = ow_width(MAX_OUT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WAYS-1:0]    i_req_v,
    output logic [WAYS-1:0]    i_req_r,
    input  logic [WAYS*LW-1:0] i_lvl,
    output logic               o_req_v,
    input  logic               o_req_r,
    output logic [SW-1:0]      o_req_sel,
    input  logic               i_cmp_v,
    input  logic [SW-1:0]      i_cmp_sel,
    output logic               o_err
);

    // One extra bit on both sums, so a committed count can never wrap.
    localparam int unsigned KW = LW + 1;
    localparam int unsigned EW = OW + 1;

    sched_state_t     state_q, state_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [SW-1:0]    rr_q, rr_d;
    logic [OW-1:0]    out_q [WAYS];
    logic [OW-1:0]    out_d [WAYS];
    logic             err_q, err_d;

    logic [EW-1:0]    eff [WAYS];
    logic [WAYS*KW-1:0] fill;
    logic [WAYS-1:0]  elig;
    logic             any;
    logic [SW-1:0]    winner;
    logic             issue;

    assign o_req_v   = (state_q == StOffer);
    assign o_req_sel = sel_q;
    assign o_err     = err_q;
    assign issue     = o_req_v && o_req_r;

    // Effective count, fill key and eligibility per stream. The offered request counts as issued.
    always_comb begin
        logic [KW-1:0] f;
        f = '0;
        for (int k = 0; k < WAYS; k++) begin
            eff[k] = EW'(out_q[k]) + EW'(o_req_v && (sel_q == SW'(k)));
            f      = KW'(i_lvl[k*LW +: LW]) + KW'(eff[k]);
            fill[k*KW +: KW] = f;
            elig[k] = i_req_v[k] && (eff[k] < EW'(MAX_OUT)) && (f < KW'(CAP));
        end
    end

    l2_sched_pick #(
        .WAYS (WAYS),
        .KW   (KW),
        .SW   (SW)
    ) u_pick (
        .elig   (elig),
        .keys   (fill),
        .rr_ptr (rr_q),
        .any    (any),
        .winner (winner)
    );

    // One-hot grant pulse for the stream whose offer is accepted this cycle.
    always_comb begin
        for (int k = 0; k < WAYS; k++) begin
            i_req_r[k] = issue && (sel_q == SW'(k));
        end
    end

    // Offer FSM. A new winner is loaded from idle, or on the cycle the current offer is accepted.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        case (state_q)
            StIdle: begin
                if (any) begin
                    state_d = StOffer;
                    sel_d   = winner;
                    rr_d    = winner + SW'(1);
                end
            end
            StOffer: begin
                if (o_req_r) begin
                    if (any) begin
                        sel_d = winner;
                        rr_d  = winner + SW'(1);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outstanding counters. An issue and a completion in the same cycle cancel out. A stray
    // completion leaves the count at zero and sets the sticky error flag.
    always_comb begin
        logic inc, dec;
        inc   = 1'b0;
        dec   = 1'b0;
        err_d = err_q;
        for (int k = 0; k < WAYS; k++) begin
            inc      = issue && (sel_q == SW'(k));
            dec      = i_cmp_v && (i_cmp_sel == SW'(k));
            out_d[k] = out_q[k];
            if (inc && !dec) begin
                out_d[k] = out_q[k] + OW'(1);
            end else if (dec && !inc) begin
                if (out_q[k] == '0) begin
                    err_d = 1'b1;
                end else begin
                    out_d[k] = out_q[k] - OW'(1);
                end
            end
        end
    end

    // State registers. Reset drops any pending offer at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            sel_q   <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < WAYS; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            for (int k = 0; k < WAYS; k++) begin
                out_q[k] <= out_d[k];
            end
        end
    end

endmodule
